// File: rtl/md_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_func, md_sign, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_func, md_sign, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Define MD_MADD_EN to enable MADD/MADDU (md_func 101).
module md_unit #(
    parameter int MUL_CYCLES = 5
) (
    input logic     clk,
    input logic     rst,
    md_unit_if.slave md
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DFIX = 2'd3;

    localparam logic [2:0] F_MULT = 3'b001;
    localparam logic [2:0] F_DIV  = 3'b010;
    localparam logic [2:0] F_MTHI = 3'b011;
    localparam logic [2:0] F_MTLO = 3'b100;
    localparam logic [2:0] F_MADD = 3'b101;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

`ifdef MD_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sgn;
    logic        madd;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [63:0] mul_res;
    logic [32:0] trial;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Sign-extending to 64 bits makes one multiplier serve both signednesses.
    assign ext_a   = {{32{sgn & op_a[31]}}, op_a};
    assign ext_b   = {{32{sgn & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;
    assign mul_res = madd ? ({hi_r, lo_r} + product) : product;

    assign trial = {rem, quo[31]} - {1'b0, op_b};

    assign a_abs = (md.md_sign & md.a[31]) ? -md.a : md.a;
    assign b_abs = (md.md_sign & md.b[31]) ? -md.b : md.b;
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    assign md.busy = (state != IDLE);
    assign md.done = done_r;
    assign md.hi   = hi_r;
    assign md.lo   = lo_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sgn      <= 1'b0;
            madd     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (md.cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (md.start) begin
                            case (md.md_func)
                                F_MTHI: hi_r <= md.a;
                                F_MTLO: lo_r <= md.a;
                                F_MULT, F_MADD: begin
                                    if (md.md_func == F_MULT || MADD_EN) begin
                                        op_a  <= md.a;
                                        op_b  <= md.b;
                                        sgn   <= md.md_sign;
                                        madd  <= (md.md_func == F_MADD);
                                        cnt   <= MUL_LAST;
                                        state <= MUL;
                                    end
                                end
                                F_DIV: begin
                                    op_a     <= md.a;
                                    op_b     <= b_abs;
                                    quo      <= a_abs;
                                    rem      <= '0;
                                    neg_q    <= md.md_sign & (md.a[31] ^ md.b[31]);
                                    neg_r    <= md.md_sign & md.a[31];
                                    div_zero <= (md.b == '0);
                                    cnt      <= 5'd31;
                                    state    <= DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt == '0) begin
                            {hi_r, lo_r} <= mul_res;
                            done_r       <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    DIV: begin
                        // Restoring step: keep the subtraction only if it did not borrow.
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt - 5'd1;
                        if (cnt == '0) state <= DFIX;
                    end
                    DFIX: begin
                        if (div_zero) begin
                            lo_r <= 32'hFFFF_FFFF;
                            hi_r <= op_a;
                        end else begin
                            lo_r <= q_fix;
                            hi_r <= r_fix;
                        end
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the EX stage and is driven by the EX control fields MDFunc, MDSign, MDHIWB and MDLOWB.
- EX supplies the operands f_rd1/f_rd2 and reads HI/LO for MFHI/MFLO.
- The controller stalls ID/EX while busy is high.

Parameters:
- MUL_CYCLES, default 5: number of busy cycles for MULT/MULTU; legal range 1..31.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  EX holds a valid MD instruction this cycle.
- md_func  in  3  000 none, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, 101 MADD (optional feature only); other codes are no-ops.
- md_sign  in  1  1 = signed operation, 0 = unsigned.
- a  in  32  rs operand (multiplicand, dividend, or MTHI/MTLO data).
- b  in  32  rt operand (multiplier or divisor).
- cancel  in  1  EX flush; aborts any operation in flight.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse on the cycle after HI/LO are written by a mult/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: the following are forced to zero on any rising edge with rst=1, including mid-operation.
  - hi, lo, busy, done.
  - Counter.
  - State, which returns to IDLE.
- FSM states: IDLE, MUL, DIV, DFIX.
- IDLE, start=1, md_func=MTHI: hi<=a at the edge; single cycle; busy stays 0; done stays 0.
- IDLE, start=1, md_func=MTLO: lo<=a, otherwise the same as MTHI.
- IDLE, start=1, md_func=MULT: latch a, b and md_sign; counter<=MUL_CYCLES-1; go to MUL; busy=1 from the next cycle.
- MUL state:
  - Each cycle, counter decrements.
  - When counter==0, write {hi,lo} <= 64-bit product, signed or unsigned according to the latched sign, then go to IDLE.
  - busy is high for exactly MUL_CYCLES cycles.
- IDLE, start=1, md_func=DIV: latch operands; for signed, latch their absolute values and the two sign bits; counter<=31; go to DIV.
- DIV state: one restoring-division step per cycle, 32 steps (counter 31..0); then go to DFIX.
- DFIX state:
  - Apply the sign fix and write lo<=quotient, hi<=remainder.
  - Signed results: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Go to IDLE.
  - busy is high for exactly 33 cycles.
- Divide by zero (b==0), either sign: lo<=32'hFFFFFFFF, hi<=a. Still takes 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo<=32'h80000000, hi<=0.
- done is 1 for exactly one cycle, immediately after the last busy cycle; 0 otherwise.
- start while busy: ignored, including MTHI/MTLO. The controller guarantees a stall in this case.
- cancel=1 while busy:
  - Return to IDLE at that edge; busy<=0; no done pulse.
  - hi and lo keep their pre-operation values.
- cancel=1 in IDLE together with start: start is ignored.
- rst and cancel asserted together: rst wins.
- Reserved md_func codes: no state change.
- hi and lo change only at MTHI/MTLO edges and final-result edges. They are stable while busy, so EX may read them in any non-busy cycle.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - md_func=101 is MADD/MADDU (signedness from md_sign).
  - Timing is identical to MULT.
  - On completion, {hi,lo} <= {hi,lo} + product, wrapping modulo 2^64.
  - The accumulator is the {hi,lo} value at the final edge.
- Undefined: 101 is a reserved no-op.

Test Plan:
- Reset mid-DIV:
  - Stimulus: after 10 DIV cycles, pulse rst.
  - Required: busy=0, hi=lo=0 on the next cycle; done never pulses.
- MULT signed, a=0xFFFFFFFE (-2), b=3, MUL_CYCLES=5:
  - Required: busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- DIV signed, a=-7 (0xFFFFFFF9), b=2:
  - Required: after 33 busy cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, a=100, b=0:
  - Required: after 33 cycles, lo=0xFFFFFFFF, hi=100.
- MTHI and cancel:
  - MTHI a=0x12345678: hi updates the next cycle with busy=0.
  - Then MULTU a=b=0x10000, with cancel at busy cycle 2: hi stays 0x12345678, lo unchanged, no done.
- Start while busy and back-to-back (with MD_MADD_EN):
  - MTLO issued while DIV is busy is ignored.
  - MADDU a=2, b=3 with hi=0, lo=0xFFFFFFFF: result hi=1, lo=5.
